// File: rtl/dtree_pkg.sv
// Shared constants, FSM state encoding and feature-slot addressing for the
// decision-tree sample loader.
package dtree_pkg;

  localparam int unsigned N_FEAT = 6;
  localparam int unsigned FEAT_W = 8;
  localparam int unsigned CLS_W  = 2;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SETTLE  = 2'd1,
    RESULT  = 2'd2,
    DISCARD = 2'd3
  } state_t;

  // Bit offset of feature slot i inside the packed feature vector.
  function automatic int unsigned feat_slot(input int unsigned i,
                                            input int unsigned w = FEAT_W);
    return i * w;
  endfunction

endpackage

// File: rtl/dtree_sample_loader.sv
// Byte-serial feature loader for the combinational decision-tree classifier:
// assembles one sample, holds it stable for a settle window, captures the
// class and hands it out over a valid/ready result port.
module dtree_sample_loader #(
  parameter int unsigned N_FEAT = dtree_pkg::N_FEAT,
  parameter int unsigned FEAT_W = dtree_pkg::FEAT_W,
  parameter int unsigned CLS_W  = dtree_pkg::CLS_W,
  parameter int unsigned SETTLE = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [N_FEAT*FEAT_W-1:0] feat,
  input  logic [CLS_W-1:0]         cls_in,
  output logic                     m_valid,
  output logic [CLS_W-1:0]         m_class,
  input  logic                     m_ready,
  output logic [CNT_W-1:0]         smp_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     err_pulse
);

  import dtree_pkg::*;

  localparam int unsigned IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned SCW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_FEAT - 1);
  localparam logic [SCW-1:0]   SETTLE_INIT = SCW'(SETTLE - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [SCW-1:0]   settle_cnt;

  logic beat;
  logic load_wr, idx_inc, idx_clr, frame_err;
  logic settle_ld, settle_dec, capture, deliver;

  // The parameter SETTLE hides the imported state label, so it is qualified.
  assign s_ready = (state == LOAD) || (state == DISCARD);
  assign beat    = s_valid && s_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    next_state = state;
    load_wr    = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    frame_err  = 1'b0;
    settle_ld  = 1'b0;
    settle_dec = 1'b0;
    capture    = 1'b0;
    deliver    = 1'b0;
    case (state)
      LOAD: begin
        if (beat) begin
          load_wr = 1'b1;
          if (idx == LAST_IDX) begin
            idx_clr = 1'b1;
            if (s_last) begin
              settle_ld  = 1'b1;
              next_state = dtree_pkg::SETTLE;
            end else begin
              frame_err  = 1'b1;
              next_state = DISCARD;
            end
          end else if (s_last) begin
            frame_err = 1'b1;
            idx_clr   = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (beat && s_last) begin
          idx_clr    = 1'b1;
          next_state = LOAD;
        end
      end
      dtree_pkg::SETTLE: begin
        if (settle_cnt == '0) begin
          capture    = 1'b1;
          next_state = RESULT;
        end else begin
          settle_dec = 1'b1;
        end
      end
      RESULT: begin
        if (m_ready) begin
          deliver    = 1'b1;
          next_state = LOAD;
        end
      end
      default: next_state = LOAD;
    endcase
  end

  // Slot index, settle timer, result register, counters and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      settle_cnt <= '0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      smp_cnt    <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
    end else begin
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;

      if (settle_ld)       settle_cnt <= SETTLE_INIT;
      else if (settle_dec) settle_cnt <= settle_cnt - 1'b1;

      if (capture) begin
        m_class <= cls_in;
        m_valid <= 1'b1;
      end else if (deliver) begin
        m_valid <= 1'b0;
      end

      if (deliver && (smp_cnt != '1))   smp_cnt <= smp_cnt + 1'b1;
      if (frame_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      err_pulse <= frame_err;
    end
  end

  // Feature register file; only accepted LOAD beats write it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat <= '0;
    end else if (load_wr) begin
      for (int unsigned i = 0; i < N_FEAT; i++) begin
        if (idx == IDX_W'(i)) feat[feat_slot(i, FEAT_W) +: FEAT_W] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_dtree_sample_loader.sv
// Directed bench for the sample loader, run with 4-bit counters so that
// saturation is reachable in a short run.
module tb_dtree_sample_loader;

  localparam int unsigned NF   = 6;
  localparam int unsigned FW   = 8;
  localparam int unsigned CW   = 2;
  localparam int unsigned ST   = 3;
  localparam int unsigned CNTW = 4;
  localparam int unsigned SAT  = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic [FW-1:0]     s_data;
  logic              s_last;
  logic              s_ready;
  logic [NF*FW-1:0]  feat;
  logic [CW-1:0]     cls_in;
  logic              m_valid;
  logic [CW-1:0]     m_class;
  logic              m_ready;
  logic [CNTW-1:0]   smp_cnt;
  logic [CNTW-1:0]   err_cnt;
  logic              err_pulse;

  dtree_sample_loader #(
    .N_FEAT(NF), .FEAT_W(FW), .CLS_W(CW), .SETTLE(ST), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .feat(feat), .cls_in(cls_in),
    .m_valid(m_valid), .m_class(m_class), .m_ready(m_ready),
    .smp_cnt(smp_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  beats [6];
    logic [1:0]  cls;
    logic [47:0] exp_feat;
    logic [1:0]  exp_class;
  } vec_t;

  vec_t        tbl [4];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_smp = 0;
  int unsigned exp_err = 0;
  logic [7:0]  bb [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one beat and return just after the edge that accepts it.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int unsigned w;
    w = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) chk("s_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  // Count edges from the last acceptance edge until m_valid shows up.
  task automatic wait_valid(output int unsigned edges);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      n++;
      if (!m_valid) chk("s_ready_settle", 64'(s_ready), 64'd0);
    end while (!m_valid && n < 30);
    if (!m_valid) chk("m_valid_timeout", 64'd0, 64'd1);
    edges = n - 1;
  endtask

  task automatic bump_smp();
    if (exp_smp < SAT) exp_smp++;
  endtask

  task automatic bump_err();
    if (exp_err < SAT) exp_err++;
  endtask

  task automatic run_sample(input logic [7:0] b [6], input logic [1:0] c,
                            input logic [47:0] ef, input logic [1:0] ec);
    int unsigned e;
    cls_in  = c;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_beat(b[i], (i == 5));
    wait_valid(e);
    chk("latency", 64'(e), 64'(ST));
    chk("feat", 64'(feat), 64'(ef));
    chk("m_class", 64'(m_class), 64'(ec));
    chk("s_ready_result", 64'(s_ready), 64'd0);
    @(negedge clk);
    bump_smp();
    chk("m_valid_after_hs", 64'(m_valid), 64'd0);
    chk("smp_cnt", 64'(smp_cnt), 64'(exp_smp));
    chk("s_ready_after_hs", 64'(s_ready), 64'd1);
  endtask

  task automatic early_frame();
    send_beat(8'h5A, 1'b0);
    send_beat(8'hA5, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    bump_err();
    chk("err_pulse_early", 64'(err_pulse), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_feat"}, 64'(feat), 64'd0);
    chk({tag, "_smp_cnt"}, 64'(smp_cnt), 64'd0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e;
    logic [1:0] cls_t;

    tbl[0].beats = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    tbl[0].cls = 2'b10; tbl[0].exp_feat = 48'h605040302010; tbl[0].exp_class = 2'b10;
    tbl[1].beats = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    tbl[1].cls = 2'b01; tbl[1].exp_feat = 48'h060504030201; tbl[1].exp_class = 2'b01;
    tbl[2].beats = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'h0F, 8'hF0};
    tbl[2].cls = 2'b11; tbl[2].exp_feat = 48'hF00F55AA00FF; tbl[2].exp_class = 2'b11;
    tbl[3].beats = '{8'h80, 8'h7F, 8'h01, 8'hFE, 8'hC3, 8'h3C};
    tbl[3].cls = 2'b00; tbl[3].exp_feat = 48'h3CC3FE017F80; tbl[3].exp_class = 2'b00;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    cls_in = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    chk("reset_m_class", 64'(m_class), 64'd0);
    chk("reset_err_pulse", 64'(err_pulse), 64'd0);
    rst_n = 1'b1;

    // Table of clean samples.
    for (int k = 0; k < 4; k++)
      run_sample(tbl[k].beats, tbl[k].cls, tbl[k].exp_feat, tbl[k].exp_class);

    // Result backpressure with cls_in wiggling during RESULT.
    cls_in = tbl[0].cls; m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(tbl[0].beats[i], (i == 5));
    wait_valid(e);
    chk("bp_latency", 64'(e), 64'(ST));
    cls_t = tbl[0].cls;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cls_t = ~cls_t; cls_in = cls_t;
      s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
      chk("bp_m_valid", 64'(m_valid), 64'd1);
      chk("bp_m_class", 64'(m_class), 64'(tbl[0].exp_class));
      chk("bp_feat", 64'(feat), 64'(tbl[0].exp_feat));
      chk("bp_s_ready", 64'(s_ready), 64'd0);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    bump_smp();
    chk("bp_m_valid_hs", 64'(m_valid), 64'd0);
    chk("bp_smp_cnt", 64'(smp_cnt), 64'(exp_smp));
    @(negedge clk);
    chk("bp_smp_cnt_once", 64'(smp_cnt), 64'(exp_smp));
    chk("bp_feat_after", 64'(feat), 64'(tbl[0].exp_feat));

    // Early s_last on the third beat.
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    bump_err();
    chk("early_err_pulse", 64'(err_pulse), 64'd1);
    chk("early_err_cnt", 64'(err_cnt), 64'(exp_err));
    @(negedge clk);
    chk("early_err_pulse_off", 64'(err_pulse), 64'd0);
    repeat (4) @(negedge clk);
    chk("early_no_m_valid", 64'(m_valid), 64'd0);
    run_sample(tbl[1].beats, tbl[1].cls, tbl[1].exp_feat, tbl[1].exp_class);

    // Back-to-back framing errors: s_last on the first beat twice.
    send_beat(8'h77, 1'b1);
    send_beat(8'h78, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    bump_err(); bump_err();
    chk("b2b_err_pulse", 64'(err_pulse), 64'd1);
    chk("b2b_err_cnt", 64'(err_cnt), 64'(exp_err));
    @(negedge clk);
    chk("b2b_err_pulse_off", 64'(err_pulse), 64'd0);

    // Missing s_last: eight beats, s_last on the eighth.
    for (int i = 0; i < 6; i++) send_beat(8'hA0 + 8'(i), 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    bump_err();
    chk("miss_err_pulse", 64'(err_pulse), 64'd1);
    send_beat(8'hA6, 1'b0);
    send_beat(8'hA7, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    chk("miss_err_cnt", 64'(err_cnt), 64'(exp_err));
    chk("miss_feat", 64'(feat), 64'h0000A5A4A3A2A1A0);
    chk("miss_no_m_valid", 64'(m_valid), 64'd0);
    chk("miss_s_ready", 64'(s_ready), 64'd1);
    run_sample(tbl[2].beats, tbl[2].cls, tbl[2].exp_feat, tbl[2].exp_class);

    // Reset while settling.
    cls_in = tbl[3].cls; m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(tbl[3].beats[i], (i == 5));
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_settle");
    @(negedge clk);
    rst_n = 1'b1;
    exp_smp = 0; exp_err = 0;
    repeat (5) @(negedge clk);
    chk("rst_settle_no_valid", 64'(m_valid), 64'd0);

    // Reset while holding a result.
    cls_in = tbl[0].cls;
    for (int i = 0; i < 6; i++) send_beat(tbl[0].beats[i], (i == 5));
    wait_valid(e);
    chk("rst_result_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_result");
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(tbl[3].beats, tbl[3].cls, tbl[3].exp_feat, tbl[3].exp_class);

    // Counter saturation.
    for (int k = 0; k < 18; k++)
      run_sample(tbl[k % 4].beats, tbl[k % 4].cls, tbl[k % 4].exp_feat, tbl[k % 4].exp_class);
    chk("smp_cnt_sat", 64'(smp_cnt), 64'hF);
    for (int k = 0; k < 18; k++) early_frame();
    chk("err_cnt_sat", 64'(err_cnt), 64'hF);
    bb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    run_sample(bb, 2'b01, 48'h3412EFBEADDE, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
